// File: rtl/pcie_bar_regfile_ring.sv
// rtl/pcie_bar_regfile_ring.sv - BAR1 PIO register file with DMA buffer ring and shadowed DAC words
module pcie_bar_regfile_ring #(
  parameter int          N_BUF   = 16,
  parameter int          N_DAC   = 8,
  parameter int          DAC_W   = 16,
  parameter logic [2:0]  BAR_SEL = 3'b001,
  parameter bit          SWAP_EN = 1'b1,
  parameter logic [15:0] DAC_RST = 16'h8000
) (
  input  logic                   trn_clk,
  input  logic                   pio_reset_n,
  input  logic [10:0]            rd_addr,
  output logic [31:0]            rd_data,
  input  logic [10:0]            wr_addr,
  input  logic [31:0]            wr_data,
  input  logic                   wr_en,
  output logic                   wr_busy,
  input  logic [31:0]            status,
  input  logic [31:0]            time_counter,
  input  logic                   dma_buf_done,
  output logic [31:0]            command,
  output logic [29:0]            dma_host_addr,
  output logic [24:0]            dma_size,
  output logic [15:0]            dma_flag_words,
  output logic [4:0]             dma_curr_buf,
  output logic                   dma_overflow,
  output logic [15:0]            reg_offset,
  output logic [31:0]            reg_data,
  output logic                   reg_wrt_en,
  output logic [15:0]            integr_decim,
  output logic [31:0]            chop_max_count,
  output logic [31:0]            chop_change_count,
  output logic [N_DAC*DAC_W-1:0] dac_data
);

  // DAC reset word, zero-extended then cut down to the channel width
  localparam logic [31:0]      DAC_RST_X = {16'h0000, DAC_RST};
  localparam logic [DAC_W-1:0] DAC_RST_W = DAC_RST_X[DAC_W-1:0];

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  logic [29:0]      dma_buf    [N_BUF];
  logic [DAC_W-1:0] dac_shadow [N_DAC];
  logic [DAC_W-1:0] dac_active [N_DAC];
  logic [5:0]       nbuf;
  logic [5:0]       fill;

  logic [31:0] wde;
  logic [7:0]  woff;
  logic [7:0]  roff;
  logic        wr_commit;
  logic [31:0] rd_word;

  // Ring next-state terms
  logic [5:0] ack_cnt;
  logic       ack_clr;
  logic       ring_full;
  logic [6:0] fill_sum;
  logic [6:0] fill_sat;
  logic [5:0] fill_nxt;
  logic [4:0] curr_nxt;
  logic       ovf_nxt;
  logic [5:0] nbuf_clamped;

  assign wde  = SWAP_EN ? bswap(wr_data) : wr_data;
  assign woff = wr_addr[7:0];
  assign roff = rd_addr[7:0];
  // wr_busy tracks wr_en one edge late, so a held strobe only sees busy=0 once
  assign wr_commit = wr_en && !wr_busy && (wr_addr[10:8] == BAR_SEL);

  for (genvar g = 0; g < N_DAC; g++) begin : g_dac_out
    assign dac_data[g*DAC_W +: DAC_W] = dac_active[g];
  end

  // Current buffer host address, muxed straight from the ring registers
  always_comb begin
    dma_host_addr = '0;
    for (int i = 0; i < N_BUF; i++) begin
      if (dma_curr_buf == 5'(i)) dma_host_addr = dma_buf[i];
    end
  end

  // Ring bookkeeping: full test uses pre-ack fill, then done/ack are netted with saturation
  always_comb begin
    ack_cnt = '0;
    ack_clr = 1'b0;
    if (wr_commit && woff == 8'h07) begin
      ack_cnt = wde[5:0];
      ack_clr = wde[31];
    end
    ring_full = (fill == nbuf);
    fill_sum  = {1'b0, fill} + {6'b0, dma_buf_done};
    if ({1'b0, ack_cnt} >= fill_sum) fill_sat = '0;
    else                             fill_sat = fill_sum - {1'b0, ack_cnt};
    if (fill_sat > {1'b0, nbuf}) fill_sat = {1'b0, nbuf};
    fill_nxt = fill_sat[5:0];
    curr_nxt = dma_curr_buf;
    if (dma_buf_done && !ring_full) begin
      if ({1'b0, dma_curr_buf} == nbuf - 6'd1) curr_nxt = '0;
      else                                     curr_nxt = dma_curr_buf + 5'd1;
    end
    ovf_nxt = dma_overflow;
    if (ack_clr) ovf_nxt = 1'b0;
    if (dma_buf_done && ring_full) ovf_nxt = 1'b1;
    if (wde[5:0] == 6'd0)              nbuf_clamped = 6'd1;
    else if (wde[5:0] > 6'(N_BUF))     nbuf_clamped = 6'(N_BUF);
    else                               nbuf_clamped = wde[5:0];
  end

  // Register writes, ring state and write handshake
  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) begin
      wr_busy           <= 1'b0;
      command           <= '0;
      dma_size          <= '0;
      dma_flag_words    <= 16'h8000;
      dma_curr_buf      <= '0;
      fill              <= '0;
      nbuf              <= 6'(N_BUF);
      dma_overflow      <= 1'b0;
      reg_offset        <= '0;
      reg_data          <= '0;
      reg_wrt_en        <= 1'b0;
      integr_decim      <= 16'd200;
      chop_max_count    <= 32'd1024;
      chop_change_count <= 32'd512;
      for (int i = 0; i < N_BUF; i++) dma_buf[i] <= '0;
      for (int i = 0; i < N_DAC; i++) begin
        dac_shadow[i] <= DAC_RST_W;
        dac_active[i] <= DAC_RST_W;
      end
    end else begin
      wr_busy      <= wr_en;
      reg_wrt_en   <= wr_commit && (woff == 8'h09);
      dma_curr_buf <= curr_nxt;
      fill         <= fill_nxt;
      dma_overflow <= ovf_nxt;
      if (wr_commit) begin
        case (woff)
          8'h01: command           <= wde;
          8'h03: dma_size          <= wde[31:7];
          8'h04: dma_flag_words    <= wde[18:3];
          8'h06: begin
            // Resizing the ring restarts it, even over a same-edge buffer completion
            nbuf         <= nbuf_clamped;
            dma_curr_buf <= '0;
            fill         <= '0;
          end
          8'h08: reg_offset        <= wde[15:0];
          8'h09: reg_data          <= wde;
          8'h0A: integr_decim      <= wde[15:0];
          8'h0B: for (int i = 0; i < N_DAC; i++) dac_active[i] <= dac_shadow[i];
          8'h0C: chop_max_count    <= wde;
          8'h0D: chop_change_count <= wde;
          default: ;
        endcase
        for (int i = 0; i < N_BUF; i++) begin
          if (woff == 8'h20 + 8'(i)) dma_buf[i] <= wde[31:2];
        end
        for (int i = 0; i < N_DAC; i++) begin
          if (woff == 8'h40 + 8'(i)) dac_shadow[i] <= wde[DAC_W-1:0];
        end
      end
    end
  end

  // Read selection; the BAR match is tested first so the region wins over the low-page marker
  always_comb begin
    rd_word = 32'h0;
    if (rd_addr[10:8] == BAR_SEL) begin
      rd_word = {16'h0001, 5'b0, rd_addr};
      case (roff)
        8'h00: rd_word = status;
        8'h01: rd_word = command;
        8'h02: rd_word = time_counter;
        8'h03: rd_word = {dma_size, 7'b0};
        8'h04: rd_word = {13'b0, dma_flag_words, 3'b0};
        8'h05: rd_word = {dma_overflow, 7'b0, 2'b0, fill, 11'b0, dma_curr_buf};
        8'h06: rd_word = {26'b0, nbuf};
        8'h08: rd_word = {16'b0, reg_offset};
        8'h09: rd_word = reg_data;
        8'h0A: rd_word = {16'b0, integr_decim};
        8'h0C: rd_word = chop_max_count;
        8'h0D: rd_word = chop_change_count;
        default: ;
      endcase
      for (int i = 0; i < N_BUF; i++) begin
        if (roff == 8'h20 + 8'(i)) rd_word = {dma_buf[i], 2'b0};
      end
      for (int i = 0; i < N_DAC; i++) begin
        if (roff == 8'h40 + 8'(i)) rd_word = 32'(dac_shadow[i]);
        if (roff == 8'h60 + 8'(i)) rd_word = 32'(dac_active[i]);
      end
    end else if (rd_addr[10:9] == 2'b00) begin
      rd_word = 32'h55000000;
    end else begin
      rd_word = {21'h0, rd_addr};
    end
  end

  // One-cycle registered read port
  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) rd_data <= '0;
    else              rd_data <= SWAP_EN ? bswap(rd_word) : rd_word;
  end

endmodule

// File: tb/tb_pcie_bar_regfile_ring.sv
// tb/tb_pcie_bar_regfile_ring.sv - directed scoreboard bench for pcie_bar_regfile_ring
module tb_pcie_bar_regfile_ring;

  logic         trn_clk = 1'b0;
  logic         pio_reset_n;
  logic [10:0]  rd_addr;
  logic [31:0]  rd_data;
  logic [10:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         wr_en;
  logic         wr_busy;
  logic [31:0]  status;
  logic [31:0]  time_counter;
  logic         dma_buf_done;
  logic [31:0]  command;
  logic [29:0]  dma_host_addr;
  logic [24:0]  dma_size;
  logic [15:0]  dma_flag_words;
  logic [4:0]   dma_curr_buf;
  logic         dma_overflow;
  logic [15:0]  reg_offset;
  logic [31:0]  reg_data;
  logic         reg_wrt_en;
  logic [15:0]  integr_decim;
  logic [31:0]  chop_max_count;
  logic [31:0]  chop_change_count;
  logic [127:0] dac_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int busy_hi;
  int wrt_hi;

  pcie_bar_regfile_ring dut (
    .trn_clk(trn_clk), .pio_reset_n(pio_reset_n),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy),
    .status(status), .time_counter(time_counter), .dma_buf_done(dma_buf_done),
    .command(command), .dma_host_addr(dma_host_addr), .dma_size(dma_size),
    .dma_flag_words(dma_flag_words), .dma_curr_buf(dma_curr_buf),
    .dma_overflow(dma_overflow), .reg_offset(reg_offset), .reg_data(reg_data),
    .reg_wrt_en(reg_wrt_en), .integr_decim(integr_decim),
    .chop_max_count(chop_max_count), .chop_change_count(chop_change_count),
    .dac_data(dac_data)
  );

  always #5 trn_clk = ~trn_clk;

  function automatic logic [31:0] bsw(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register-level write: v is the value the register should hold, sent byte-swapped
  task automatic wr(input logic [10:0] a, input logic [31:0] v);
    wr_addr = a;
    wr_data = bsw(v);
    wr_en   = 1'b1;
    @(negedge trn_clk);
    wr_en   = 1'b0;
    @(negedge trn_clk);
  endtask

  // Read with one-cycle latency; expected bus value pushed at issue, popped when data is due
  task automatic rd(input logic [10:0] a, input logic [31:0] r, input string tag);
    rd_addr = a;
    exp_q.push_back(bsw(r));
    tag_q.push_back(tag);
    @(negedge trn_clk);
    check(tag_q.pop_front(), rd_data, exp_q.pop_front());
  endtask

  task automatic done_pulse();
    dma_buf_done = 1'b1;
    @(negedge trn_clk);
    dma_buf_done = 1'b0;
  endtask

  initial begin
    pio_reset_n  = 1'b0;
    rd_addr      = '0;
    wr_addr      = '0;
    wr_data      = '0;
    wr_en        = 1'b0;
    status       = 32'hDEAD0001;
    time_counter = 32'h0;
    dma_buf_done = 1'b0;
    repeat (2) @(negedge trn_clk);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_wr_busy", {31'b0, wr_busy}, 32'h0);
    check("rst_command", command, 32'h0);
    check("rst_flag_words", {16'b0, dma_flag_words}, 32'h8000);
    check("rst_chop_max", chop_max_count, 32'd1024);
    check("rst_chop_change", chop_change_count, 32'd512);
    check("rst_dac0", {16'b0, dac_data[15:0]}, 32'h8000);
    check("rst_dac7", {16'b0, dac_data[127:112]}, 32'h8000);
    pio_reset_n = 1'b1;
    @(negedge trn_clk);

    rd(11'h10A, 32'd200, "rd_decim");
    rd(11'h104, 32'h00040000, "rd_thres");
    rd(11'h106, 32'd16, "rd_nbuf_rst");
    rd(11'h100, 32'hDEAD0001, "rd_status");

    // Held strobe: one commit, busy for the whole hold
    busy_hi = 0;
    wrt_hi  = 0;
    wr_addr = 11'h109;
    wr_data = 32'hAABBCCDD;
    wr_en   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge trn_clk);
      busy_hi += int'(wr_busy);
      wrt_hi  += int'(reg_wrt_en);
    end
    wr_en = 1'b0;
    @(negedge trn_clk);
    busy_hi += int'(wr_busy);
    wrt_hi  += int'(reg_wrt_en);
    check("hold_reg_data", reg_data, 32'hDDCCBBAA);
    check("hold_busy_cycles", 32'(busy_hi), 32'd5);
    check("hold_wrt_pulses", 32'(wrt_hi), 32'd1);

    wr(11'h201, 32'h12345678);
    check("other_bar_ignored", command, 32'h0);
    wr(11'h101, 32'h0000A5A5);
    check("command_wr", command, 32'h0000A5A5);

    // Ring of three buffers, four completions without acknowledge
    wr(11'h106, 32'd3);
    wr(11'h120, 32'h1000);
    wr(11'h121, 32'h2000);
    wr(11'h122, 32'h3000);
    check("host_addr_b0", {2'b0, dma_host_addr}, 32'h400);
    rd(11'h120, 32'h1000, "rd_buff0");
    done_pulse();
    check("curr_after1", {27'b0, dma_curr_buf}, 32'd1);
    check("host_addr_b1", {2'b0, dma_host_addr}, 32'h800);
    done_pulse();
    check("curr_after2", {27'b0, dma_curr_buf}, 32'd2);
    done_pulse();
    check("curr_after3", {27'b0, dma_curr_buf}, 32'd0);
    check("ovf_after3", {31'b0, dma_overflow}, 32'd0);
    done_pulse();
    check("curr_after4", {27'b0, dma_curr_buf}, 32'd0);
    check("ovf_after4", {31'b0, dma_overflow}, 32'd1);
    check("host_addr_wrap", {2'b0, dma_host_addr}, 32'h400);
    rd(11'h105, 32'h80030000, "ring_full_status");

    // Completion and ACK(1) on the same edge while full
    dma_buf_done = 1'b1;
    wr_addr = 11'h107;
    wr_data = bsw(32'd1);
    wr_en   = 1'b1;
    @(negedge trn_clk);
    dma_buf_done = 1'b0;
    wr_en = 1'b0;
    @(negedge trn_clk);
    rd(11'h105, 32'h80030000, "done_ack_same_edge");
    wr(11'h107, 32'h80000003);
    rd(11'h105, 32'h00000000, "ack_clear");

    // Ring resize clears position; NBUF clamps at both ends
    done_pulse();
    rd(11'h105, 32'h00010001, "one_done");
    wr(11'h106, 32'd2);
    rd(11'h105, 32'h00000000, "nbuf_wr_clears");
    wr(11'h106, 32'd0);
    rd(11'h106, 32'd1, "nbuf_clamp_lo");
    wr(11'h106, 32'd63);
    rd(11'h106, 32'd16, "nbuf_clamp_hi");

    // Shadow writes stay invisible until DAC_LOAD
    wr(11'h141, 32'h1234);
    wr(11'h142, 32'h5678);
    check("dac1_pre_load", {16'b0, dac_data[31:16]}, 32'h8000);
    check("dac2_pre_load", {16'b0, dac_data[47:32]}, 32'h8000);
    rd(11'h141, 32'h1234, "rd_shadow1");
    wr_addr = 11'h10B;
    wr_data = 32'hFFFFFFFF;
    wr_en   = 1'b1;
    @(negedge trn_clk);
    check("dac1_load", {16'b0, dac_data[31:16]}, 32'h1234);
    check("dac2_load", {16'b0, dac_data[47:32]}, 32'h5678);
    check("dac0_load", {16'b0, dac_data[15:0]}, 32'h8000);
    wr_en = 1'b0;
    @(negedge trn_clk);
    rd(11'h161, 32'h1234, "rd_active1");

    rd(11'h000, 32'h55000000, "rd_low_page");
    rd(11'h1FF, {16'h0001, 5'b0, 11'h1FF}, "rd_unmapped");
    rd(11'h3FF, {21'h0, 11'h3FF}, "rd_other_bar");

    // Reset during a held write, then recommit after release
    wr_addr = 11'h101;
    wr_data = bsw(32'hCAFE0001);
    wr_en   = 1'b1;
    @(negedge trn_clk);
    check("mid_busy", {31'b0, wr_busy}, 32'd1);
    #2 pio_reset_n = 1'b0;
    #1;
    check("async_busy_drop", {31'b0, wr_busy}, 32'd0);
    check("async_command_clr", command, 32'h0);
    @(negedge trn_clk);
    pio_reset_n = 1'b1;
    @(negedge trn_clk);
    check("recommit_command", command, 32'hCAFE0001);
    check("recommit_busy", {31'b0, wr_busy}, 32'd1);
    wr_en = 1'b0;
    @(negedge trn_clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
